// File: rtl/fp_operand_unpack.sv
// Purpose: unpack an IEEE-754 single-precision operand pair into class, unbiased exponent and explicit-hidden-bit significand.
// Latency: 1 cycle for non-subnormal pairs, 1 + ceil(max(lz)/STEP) when a subnormal must be normalized (7 max with STEP=4).
// Backpressure: results are held in FULL until out_ready_i; input is accepted in IDLE or in FULL while draining.
//
// Ports:
//   clk_i, rstn_i            clock, async active-low reset
//   in_valid_i/in_ready_o    input handshake for rs1_i, rs2_i, rm_i
//   out_valid_o/out_ready_i  output handshake for all registered outputs
//   rs*_o, rm_o              raw operands and rounding mode, passed through
//   rs*Exp_o                 10-bit signed unbiased exponent
//   rs*Sig_o                 24-bit significand, leading 1 at bit 23 once valid
//   rs*Class_o               one-hot class: [0]ZERO [1]SUB [2]NORM [3]INF [4]SNAN [5]QNAN
module fp_operand_unpack #(
   parameter int STEP = 4
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [31:0]        rs1_i,
   input  logic [31:0]        rs2_i,
   input  logic [2:0]         rm_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [31:0]        rs1_o,
   output logic [31:0]        rs2_o,
   output logic signed [9:0]  rs1Exp_o,
   output logic signed [9:0]  rs2Exp_o,
   output logic [23:0]        rs1Sig_o,
   output logic [23:0]        rs2Sig_o,
   output logic [5:0]         rs1Class_o,
   output logic [5:0]         rs2Class_o,
   output logic [2:0]         rm_o
);

   localparam int CLS_ZERO = 0;
   localparam int CLS_SUB  = 1;
   localparam int CLS_NORM = 2;
   localparam int CLS_INF  = 3;
   localparam int CLS_SNAN = 4;
   localparam int CLS_QNAN = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      FULL = 2'd2
   } state_t;

   typedef struct packed {
      logic [5:0]        cls;
      logic signed [9:0] ex;
      logic [23:0]       sig;
   } opnd_t;

   // Leading-zero count of a 24-bit value; the highest set bit wins.
   function automatic logic [4:0] lzc24(input logic [23:0] v);
      lzc24 = 5'd24;
      for (int i = 0; i < 24; i++) begin
         if (v[i]) lzc24 = 5'(23 - i);
      end
   endfunction

   function automatic opnd_t unpack(input logic [31:0] x);
      logic [7:0]  e;
      logic [22:0] f;
      e = x[30:23];
      f = x[22:0];
      unpack.cls = '0;
      // E-127 also yields -127 for zero and +128 for INF/NaN.
      unpack.ex  = $signed({2'b00, e}) - 10'sd127;
      unpack.sig = {1'b1, f};
      if (e == 8'd0) begin
         unpack.sig = {1'b0, f};
         if (f == 23'd0) begin
            unpack.cls[CLS_ZERO] = 1'b1;
         end else begin
            unpack.cls[CLS_SUB] = 1'b1;
            unpack.ex           = -10'sd126;
         end
      end else if (e == 8'hFF) begin
         if (f == 23'd0)    unpack.cls[CLS_INF]  = 1'b1;
         else if (f[22])    unpack.cls[CLS_QNAN] = 1'b1;
         else               unpack.cls[CLS_SNAN] = 1'b1;
      end else begin
         unpack.cls[CLS_NORM] = 1'b1;
      end
   endfunction

   // Only subnormals are shifted: a ZERO operand has no leading 1 and
   // would otherwise never finish normalizing.
   function automatic opnd_t norm_step(input opnd_t o);
      logic [4:0] lz;
      logic [4:0] k;
      lz = 5'd0;
      k  = 5'd0;
      norm_step = o;
      if (o.cls[CLS_SUB] && !o.sig[23]) begin
         lz = lzc24(o.sig);
         k  = (lz > 5'(STEP)) ? 5'(STEP) : lz;
         norm_step.sig = o.sig << k;
         norm_step.ex  = o.ex - $signed({5'b00000, k});
      end
   endfunction

   function automatic logic is_done(input opnd_t o);
      is_done = !o.cls[CLS_SUB] || o.sig[23];
   endfunction

   state_t      state_q, state_d;
   opnd_t       op1_q, op1_d, op2_q, op2_d;
   logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d;
   logic [2:0]  rm_q, rm_d;

   opnd_t       new1, new2, nrm1, nrm2;
   logic        load;

   assign in_ready_o = (state_q == IDLE) || ((state_q == FULL) && out_ready_i);
   assign load       = in_valid_i && in_ready_o;

   assign new1 = unpack(rs1_i);
   assign new2 = unpack(rs2_i);
   assign nrm1 = norm_step(op1_q);
   assign nrm2 = norm_step(op2_q);

   always_comb begin
      state_d = state_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      rm_d    = rm_q;
      unique case (state_q)
         IDLE: ;
         NORM: begin
            op1_d = nrm1;
            op2_d = nrm2;
            if (is_done(nrm1) && is_done(nrm2)) state_d = FULL;
         end
         FULL: begin
            if (out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A load in FULL overrides the drain-to-IDLE transition above.
      if (load) begin
         op1_d   = new1;
         op2_d   = new2;
         rs1_d   = rs1_i;
         rs2_d   = rs2_i;
         rm_d    = rm_i;
         state_d = (new1.cls[CLS_SUB] || new2.cls[CLS_SUB]) ? NORM : FULL;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         op1_q   <= '0;
         op2_q   <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rm_q    <= '0;
      end else begin
         state_q <= state_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rm_q    <= rm_d;
      end
   end

   assign out_valid_o = (state_q == FULL);
   assign rs1_o       = rs1_q;
   assign rs2_o       = rs2_q;
   assign rm_o        = rm_q;
   assign rs1Exp_o    = op1_q.ex;
   assign rs2Exp_o    = op2_q.ex;
   assign rs1Sig_o    = op1_q.sig;
   assign rs2Sig_o    = op2_q.sig;
   assign rs1Class_o  = op1_q.cls;
   assign rs2Class_o  = op2_q.cls;

endmodule
